// File: rtl/l1_cache.sv
// Direct-mapped, write-back, write-allocate L1 cache between one pipeline
// memory port (16-bit words) and the 128-bit line-wide physical memory port.
// Hits answer combinationally in the request cycle; misses run a
// writeback/fill sequence against pmem.
module l1_cache #(
  parameter int NUM_SETS = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [15:0]  mem_address,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [1:0]   mem_byte_enable,
  input  logic [15:0]  mem_wdata,
  output logic [15:0]  mem_rdata,
  output logic         mem_resp,
  output logic [15:0]  pmem_address,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 12 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FILL} state_t;

  state_t              state;
  logic [NUM_SETS-1:0] valid;
  logic [NUM_SETS-1:0] dirty;
  logic [TAG_W-1:0]    tag  [NUM_SETS];
  logic [127:0]        data [NUM_SETS];

  // Miss target captured when leaving IDLE, so the sequence finishes
  // correctly even if the requester abandons the request mid-miss.
  logic [TAG_W-1:0]    miss_tag;
  logic [IDX_W-1:0]    miss_idx;

  logic [TAG_W-1:0]    addr_tag;
  logic [IDX_W-1:0]    idx;
  logic [2:0]          word;
  logic                req;
  logic                hit;
  logic                idle_hit;
  logic                write_hit;
  logic                addr_unused;

  assign addr_tag    = mem_address[15:4+IDX_W];
  assign idx         = mem_address[3+IDX_W:4];
  assign word        = mem_address[3:1];
  assign addr_unused = mem_address[0];
  assign req         = mem_read | mem_write;
  assign hit         = valid[idx] && (tag[idx] == addr_tag);
  assign idle_hit    = (state == IDLE) && req && hit;
  // A simultaneous read and write is treated as a write.
  assign write_hit   = idle_hit && mem_write;

  // Merge the enabled bytes of one 16-bit word into a cache line.
  function automatic logic [127:0] merge_word(input logic [127:0] line,
                                              input logic [2:0]   w,
                                              input logic [1:0]   be,
                                              input logic [15:0]  wd);
    logic [127:0] res;
    res = line;
    if (be[0]) res[{w, 4'b0000} +: 8]     = wd[7:0];
    if (be[1]) res[{w, 4'b1000} +: 8]     = wd[15:8];
    return res;
  endfunction

  // Pipeline-facing response: combinational in the request cycle on a hit.
  always_comb begin
    mem_resp  = idle_hit;
    mem_rdata = 16'h0000;
    if (idle_hit) mem_rdata = data[idx][{word, 4'b0000} +: 16];
  end

  // Memory-side strobes follow the FSM state; address is zero when idle.
  always_comb begin
    pmem_read    = (state == FILL);
    pmem_write   = (state == WRITEBACK);
    pmem_wdata   = data[miss_idx];
    pmem_address = 16'h0000;
    case (state)
      WRITEBACK: pmem_address = {tag[miss_idx], miss_idx, 4'b0000};
      FILL:      pmem_address = {miss_tag, miss_idx, 4'b0000};
      default:   pmem_address = 16'h0000;
    endcase
  end

  // Control FSM plus per-set valid/dirty bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            if (hit) begin
              if (mem_write) dirty[idx] <= 1'b1;
            end else if (valid[idx] && dirty[idx]) begin
              state <= WRITEBACK;
            end else begin
              state <= FILL;
            end
          end
        end
        WRITEBACK: begin
          if (pmem_resp) begin
            dirty[miss_idx] <= 1'b0;
            state           <= FILL;
          end
        end
        FILL: begin
          if (pmem_resp) begin
            valid[miss_idx] <= 1'b1;
            dirty[miss_idx] <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line data, tags and the captured miss target (not reset).
  always_ff @(posedge clk) begin
    if ((state == IDLE) && req && !hit) begin
      miss_tag <= addr_tag;
      miss_idx <= idx;
    end
    if (write_hit)
      data[idx] <= merge_word(data[idx], word, mem_byte_enable, mem_wdata);
    if ((state == FILL) && pmem_resp) begin
      data[miss_idx] <= pmem_rdata;
      tag[miss_idx]  <= miss_tag;
    end
  end

endmodule

// File: tb/tb_l1_cache.sv
// Testbench for l1_cache: a behavioural pmem responder with programmable
// latency, plus a flat memory image and residency table as reference model.
module tb_l1_cache;

  localparam int NS = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [15:0]  mem_address = '0;
  logic         mem_read = 1'b0;
  logic         mem_write = 1'b0;
  logic [1:0]   mem_byte_enable = '0;
  logic [15:0]  mem_wdata = '0;
  logic [15:0]  mem_rdata;
  logic         mem_resp;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  l1_cache #(.NUM_SETS(NS)) dut (
    .clk(clk), .reset(reset),
    .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: true memory contents per line, and which line each set holds.
  logic [127:0] ref_line [4096];
  logic [127:0] pmem_mem [4096];
  bit           rv   [NS];
  bit           rdty [NS];
  int           rt   [NS];

  // pmem responder bookkeeping
  int           lat = 2;
  int           wait_cnt = 0;
  int           n_wb = 0, n_fill = 0, n_resp = 0, n_acc = 0, overlap = 0;
  logic [15:0]  wb_addr, fill_addr;
  logic [127:0] wb_data;
  logic [15:0]  last_rd;
  int           last_cyc;

  // pmem model: answers after 'lat' cycles of a held strobe with a one-cycle pulse.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (pmem_read && pmem_write) overlap++;
      if (reset) begin
        wait_cnt = 0;
      end else if (pmem_read || pmem_write) begin
        wait_cnt++;
        if (wait_cnt >= lat) begin
          if (pmem_write) begin
            pmem_mem[pmem_address[15:4]] = pmem_wdata;
            wb_addr = pmem_address;
            wb_data = pmem_wdata;
            n_wb++;
          end else begin
            pmem_rdata = pmem_mem[pmem_address[15:4]];
            fill_addr  = pmem_address;
            n_fill++;
          end
          pmem_resp = 1'b1;
          wait_cnt  = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Count cycles in which the cache answers the pipeline.
  always @(negedge clk) if (mem_resp) n_resp++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  // After a reset every line is gone; dirty contents never reached pmem.
  task automatic ref_reset();
    for (int s = 0; s < NS; s++) begin
      if (rv[s] && rdty[s]) ref_line[rt[s]*NS + s] = pmem_mem[rt[s]*NS + s];
      rv[s] = 0;
      rdty[s] = 0;
    end
  endtask

  // One pipeline access, checked against the model; returns at posedge+1.
  task automatic access(input bit w, input logic [15:0] addr,
                        input logic [1:0] be, input logic [15:0] wd);
    int line, set, tg, old_line, exp_cyc, cyc, wb0, fl0, wi;
    bit exp_hit, exp_wb, got;
    logic [15:0] rd;
    line = int'(addr[15:4]);
    set  = line % NS;
    tg   = line / NS;
    wi   = int'(addr[3:1]);
    exp_hit  = rv[set] && (rt[set] == tg);
    exp_wb   = !exp_hit && rv[set] && rdty[set];
    old_line = rt[set]*NS + set;
    exp_cyc  = exp_hit ? 0 : (exp_wb ? 2*lat + 1 : lat + 1);
    wb0 = n_wb;
    fl0 = n_fill;
    mem_address = addr; mem_read = !w; mem_write = w;
    mem_byte_enable = be; mem_wdata = wd;
    cyc = 0; got = 0; rd = '0;
    while (!got && cyc <= 200) begin
      #1;
      if (mem_resp) begin
        got = 1;
        rd  = mem_rdata;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
    if (got) begin
      @(posedge clk); #1;
      n_acc++;
    end
    mem_read = 0; mem_write = 0;
    last_rd = rd; last_cyc = cyc;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL resp_timeout addr=%h: got no mem_resp required mem_resp", addr);
    end
    tests++;
    if (cyc !== exp_cyc) begin
      fails++;
      $display("FAIL latency addr=%h: got %0d cycles required %0d", addr, cyc, exp_cyc);
    end
    tests++;
    if (n_wb - wb0 !== (exp_wb ? 1 : 0)) begin
      fails++;
      $display("FAIL wb_count addr=%h: got %0d required %0d", addr, n_wb - wb0, exp_wb);
    end
    tests++;
    if (n_fill - fl0 !== (exp_hit ? 0 : 1)) begin
      fails++;
      $display("FAIL fill_count addr=%h: got %0d required %0d", addr, n_fill - fl0, !exp_hit);
    end
    if (exp_wb) begin
      tests++;
      if (wb_addr !== 16'(old_line << 4)) begin
        fails++;
        $display("FAIL wb_addr: got %h required %h", wb_addr, 16'(old_line << 4));
      end
      tests++;
      if (wb_data !== ref_line[old_line]) begin
        fails++;
        $display("FAIL wb_data: got %h required %h", wb_data, ref_line[old_line]);
      end
    end
    if (!exp_hit) begin
      tests++;
      if (fill_addr !== 16'(line << 4)) begin
        fails++;
        $display("FAIL fill_addr: got %h required %h", fill_addr, 16'(line << 4));
      end
      rv[set] = 1; rt[set] = tg; rdty[set] = 0;
    end
    if (w) begin
      if (be[0]) ref_line[line][16*wi +: 8]     = wd[7:0];
      if (be[1]) ref_line[line][16*wi + 8 +: 8] = wd[15:8];
      rdty[set] = 1;
    end else begin
      tests++;
      if (rd !== ref_line[line][16*wi +: 16]) begin
        fails++;
        $display("FAIL rdata addr=%h: got %h required %h", addr, rd, ref_line[line][16*wi +: 16]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    @(posedge clk); #1;
    tests++; if (mem_resp !== 1'b0)       begin fails++; $display("FAIL reset_resp: got %b required 0", mem_resp); end
    tests++; if (mem_rdata !== 16'h0)     begin fails++; $display("FAIL reset_rdata: got %h required 0000", mem_rdata); end
    tests++; if (pmem_read !== 1'b0)      begin fails++; $display("FAIL reset_pread: got %b required 0", pmem_read); end
    tests++; if (pmem_write !== 1'b0)     begin fails++; $display("FAIL reset_pwrite: got %b required 0", pmem_write); end
    tests++; if (pmem_address !== 16'h0)  begin fails++; $display("FAIL reset_paddr: got %h required 0000", pmem_address); end
  endtask

  task automatic test_directed();
    lat = 2;
    ref_line[4][63:48] = 16'hBEEF;
    pmem_mem[4][63:48] = 16'hBEEF;
    access(0, 16'h0040, 2'b00, 16'h0);
    access(0, 16'h0046, 2'b00, 16'h0);
    tests++; if (last_rd !== 16'hBEEF) begin fails++; $display("FAIL fill_word3: got %h required BEEF", last_rd); end
    tests++; if (last_cyc !== 0)       begin fails++; $display("FAIL hit_same_cycle: got %0d required 0", last_cyc); end
    access(1, 16'h0046, 2'b01, 16'h1234);
    access(0, 16'h0046, 2'b00, 16'h0);
    tests++; if (last_rd !== 16'hBE34) begin fails++; $display("FAIL byte_merge: got %h required BE34", last_rd); end
    access(0, 16'h00C6, 2'b00, 16'h0);
    tests++; if (wb_addr !== 16'h0040)        begin fails++; $display("FAIL dirty_wb_addr: got %h required 0040", wb_addr); end
    tests++; if (wb_data[63:48] !== 16'hBE34) begin fails++; $display("FAIL dirty_wb_word3: got %h required BE34", wb_data[63:48]); end
    tests++; if (fill_addr !== 16'h00C0)      begin fails++; $display("FAIL conflict_fill: got %h required 00C0", fill_addr); end
    tests++; if (last_cyc !== 5)              begin fails++; $display("FAIL dirty_latency: got %0d required 5", last_cyc); end
  endtask

  task automatic test_clean_conflict();
    int wb0;
    wb0 = n_wb;
    access(0, 16'h0046, 2'b00, 16'h0);
    tests++; if (n_wb !== wb0)     begin fails++; $display("FAIL clean_no_wb: got %0d writebacks required 0", n_wb - wb0); end
    tests++; if (last_rd !== 16'hBE34) begin fails++; $display("FAIL clean_refill: got %h required BE34", last_rd); end
    tests++; if (overlap !== 0)    begin fails++; $display("FAIL strobe_overlap: got %0d required 0", overlap); end
  endtask

  task automatic test_be_zero();
    int wb0;
    access(1, 16'h0046, 2'b00, 16'hFFFF);
    tests++; if (last_cyc !== 0) begin fails++; $display("FAIL be0_resp: got %0d cycles required 0", last_cyc); end
    access(0, 16'h0046, 2'b00, 16'h0);
    tests++; if (last_rd !== 16'hBE34) begin fails++; $display("FAIL be0_nochange: got %h required BE34", last_rd); end
    wb0 = n_wb;
    access(0, 16'h00C6, 2'b00, 16'h0);
    tests++; if (n_wb - wb0 !== 1) begin fails++; $display("FAIL be0_dirty: got %0d writebacks required 1", n_wb - wb0); end
  endtask

  task automatic test_drop();
    int r0, f0, w0, set, line;
    bit was_dirty, was_hit;
    lat  = 3;
    line = 16'h0100 >> 4;
    set  = line % NS;
    was_hit   = rv[set] && rt[set] == line / NS;
    was_dirty = !was_hit && rv[set] && rdty[set];
    r0 = n_resp; f0 = n_fill; w0 = n_wb;
    mem_address = 16'h0100; mem_read = 1;
    @(posedge clk); #1;
    mem_read = 0; mem_address = 16'h0000;
    repeat (12) @(posedge clk);
    #1;
    tests++; if (n_resp !== r0) begin fails++; $display("FAIL drop_no_resp: got %0d resps required 0", n_resp - r0); end
    tests++; if (n_fill - f0 !== (was_hit ? 0 : 1)) begin fails++; $display("FAIL drop_fill_done: got %0d required %0d", n_fill - f0, !was_hit); end
    tests++; if (n_wb - w0 !== (was_dirty ? 1 : 0)) begin fails++; $display("FAIL drop_wb: got %0d required %0d", n_wb - w0, was_dirty); end
    if (was_dirty) ref_line[rt[set]*NS + set] = pmem_mem[rt[set]*NS + set];
    rv[set] = 1; rt[set] = line / NS; rdty[set] = 0;
    access(0, 16'h0100, 2'b00, 16'h0);
  endtask

  task automatic test_random();
    logic [15:0] a;
    for (int i = 0; i < 300; i++) begin
      lat = $urandom_range(1, 4);
      a = 16'(($urandom_range(0, 31) << 4) | ($urandom_range(0, 7) << 1));
      access(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), 16'($urandom));
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_reset_mid_fill();
    int c;
    lat = 10;
    access(0, 16'h0020, 2'b00, 16'h0);
    mem_address = 16'h0120; mem_read = 1;
    c = 0;
    while (!pmem_read && c < 50) begin @(posedge clk); #1; c++; end
    tests++; if (pmem_read !== 1'b1) begin fails++; $display("FAIL fill_start: got %b required 1", pmem_read); end
    #2;
    reset = 1;
    #1;
    tests++; if (pmem_read !== 1'b0)  begin fails++; $display("FAIL async_drop_read: got %b required 0", pmem_read); end
    tests++; if (pmem_write !== 1'b0) begin fails++; $display("FAIL async_drop_write: got %b required 0", pmem_write); end
    mem_read = 0;
    @(posedge clk); #1;
    reset = 0;
    ref_reset();
    lat = 2;
    access(0, 16'h0020, 2'b00, 16'h0);
    tests++; if (last_cyc == 0) begin fails++; $display("FAIL post_reset_miss: got %0d cycles required 3", last_cyc); end
  endtask

  task automatic test_back_to_back();
    int r0;
    lat = 3;
    for (int s = 0; s < 4; s++) access(0, 16'(16'h0400 + 16*s), 2'b00, 16'h0);
    r0 = n_resp;
    for (int s = 0; s < 4; s++) access(0, 16'(16'h0402 + 16*s), 2'b00, 16'h0);
    tests++; if (n_resp - r0 !== 4) begin fails++; $display("FAIL b2b_resp_count: got %0d required 4", n_resp - r0); end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ref_line[i] = {$urandom, $urandom, $urandom, $urandom};
      pmem_mem[i] = ref_line[i];
    end
    for (int s = 0; s < NS; s++) begin rv[s] = 0; rdty[s] = 0; rt[s] = 0; end
    test_reset();
    test_directed();
    test_clean_conflict();
    test_be_zero();
    test_drop();
    test_random();
    test_reset_mid_fill();
    test_back_to_back();
    tests++; if (overlap !== 0)      begin fails++; $display("FAIL strobe_overlap_total: got %0d required 0", overlap); end
    tests++; if (n_resp !== n_acc)   begin fails++; $display("FAIL resp_per_request: got %0d required %0d", n_resp, n_acc); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
